// File: rtl/axis_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : axis_block_sequencer
// Purpose  : Controls one AXI-Stream kernel pass of SDIM beats, split into
//            blocks of BDIM beats. Inputs are accepted only between
//            ap_start and ap_done. Beats pass through a single-entry
//            register slice, and the last beat of each block carries tlast.
//            The block index of the next input beat is reported on blk_idx.
// Options  : `define AXIS_SEQ_PERF_EN to add the stall_cycles counter, which
//            counts output back-pressure cycles.
// Revision : 1.0 - initial release
// ============================================================================
module axis_block_sequencer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BDIM       = 32,
  parameter  int SDIM       = 1024,
  localparam int NBLK       = SDIM / BDIM,
  localparam int BIW        = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_result_tdata,
  output logic                  m_axis_result_tvalid,
  input  logic                  m_axis_result_tready,
  output logic                  m_axis_result_tlast,
  output logic [BIW-1:0]        blk_idx,
  output logic [31:0]           stall_cycles
);

  localparam int BW = (BDIM > 1) ? $clog2(BDIM) : 1;
  localparam logic [BW-1:0]  c_BEAT_MAX = BW'(BDIM - 1);
  localparam logic [BIW-1:0] c_BLK_MAX  = BIW'(NBLK - 1);

  // Reject an SDIM that is not a whole number of blocks.
  generate
    if ((BDIM < 1) || ((SDIM % BDIM) != 0)) begin : g_bad_dims
      $error("axis_block_sequencer: SDIM must be a nonzero multiple of BDIM");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [BIW-1:0]        blk_q, blk_d;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  logic in_acc;
  logic out_acc;
  logic beat_wrap;
  logic final_beat;

  assign s_axis_data_tready = (state_q == S_RUN) && (!valid_q || m_axis_result_tready);
  assign in_acc     = s_axis_data_tvalid && s_axis_data_tready;
  assign out_acc    = valid_q && m_axis_result_tready;
  assign beat_wrap  = (beat_q == c_BEAT_MAX);
  assign final_beat = beat_wrap && (blk_q == c_BLK_MAX);

  assign ap_idle              = (state_q == S_IDLE);
  assign ap_done              = (state_q == S_DONE);
  assign m_axis_result_tvalid = valid_q;
  assign m_axis_result_tdata  = data_q;
  assign m_axis_result_tlast  = last_q;
  assign blk_idx              = blk_q;

  // Pass sequencing: IDLE -> RUN -> DRAIN -> DONE (one cycle) -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = S_RUN;
      S_RUN:   if (in_acc && final_beat) state_d = S_DRAIN;
      S_DRAIN: if (!valid_q || out_acc) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat and block position, advanced only by accepted input beats.
  always_comb begin
    beat_d = beat_q;
    blk_d  = blk_q;
    if ((state_q == S_IDLE) && ap_start) begin
      beat_d = '0;
      blk_d  = '0;
    end else if (in_acc) begin
      if (beat_wrap) begin
        beat_d = '0;
        blk_d  = (blk_q == c_BLK_MAX) ? '0 : blk_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
    end
  end

  // Output register slice: load on input accept, empty on a lone output accept.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_acc) begin
      valid_q <= 1'b1;
      data_q  <= s_axis_data_tdata;
      last_q  <= beat_wrap;
    end else if (out_acc) begin
      valid_q <= 1'b0;
    end
  end

`ifdef AXIS_SEQ_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of cycles where downstream holds off a valid beat.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && ap_start) begin
      stall_q <= '0;
    end else if (((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                 valid_q && !m_axis_result_tready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
